// File: rtl/if_id_hazard_if.sv
// IF/ID hazard unit bus: groups every fetch-side, hazard-input and ID-side signal of
// if_id_hazard. Clock and reset stay as plain module ports.
//   master : the surrounding pipeline (drives IF/EX/MEM info, observes ID/control).
//   slave  : the if_id_hazard block itself.
// Optional feature macro: HAZARD_STATS_EN adds the stallCount/flushCount counters.
// When it is defined, CNT_W must match the CNT_W of the connected if_id_hazard.
interface if_id_hazard_if
`ifdef HAZARD_STATS_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ;
  logic [31:0] pcAdd4IF;
  logic [31:0] instructionIF;
  logic        branchEqID;
  logic        branchNeID;
  logic        jumpID;
  logic        regsEqualID;
  logic        memReadEX;
  logic        regWriteEX;
  logic [4:0]  writeRegEX;
  logic        memReadMEM;
  logic [4:0]  writeRegMEM;
  logic [31:0] pcAdd4ID;
  logic [31:0] instructionID;
  logic        validID;
  logic        pcWrite;
  logic        idexBubble;
  logic        ifFlush;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;
`endif

  modport master (
    output pcAdd4IF, instructionIF, branchEqID, branchNeID, jumpID, regsEqualID,
    output memReadEX, regWriteEX, writeRegEX, memReadMEM, writeRegMEM,
    input  pcAdd4ID, instructionID, validID, pcWrite, idexBubble, ifFlush
`ifdef HAZARD_STATS_EN
    ,
    input  stallCount, flushCount
`endif
  );

  modport slave (
    input  pcAdd4IF, instructionIF, branchEqID, branchNeID, jumpID, regsEqualID,
    input  memReadEX, regWriteEX, writeRegEX, memReadMEM, writeRegMEM,
    output pcAdd4ID, instructionID, validID, pcWrite, idexBubble, ifFlush
`ifdef HAZARD_STATS_EN
    ,
    output stallCount, flushCount
`endif
  );
endinterface

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register plus ID-stage hazard/stall/flush control for a 5-stage MIPS.
// Latches the fetched instruction and PC+4, detects load-use and branch-operand hazards,
// freezes PC and IF/ID on a stall, requests an ID/EX bubble, and squashes the fetched
// slot when a branch/jump resolved in ID is taken.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : if_id_hazard_if.slave (fetch inputs, EX/MEM hazard info, ID outputs,
//            pcWrite / idexBubble / ifFlush, optional statistic counters)
// Optional feature macro: HAZARD_STATS_EN builds saturating stall/flush counters of
// width CNT_W (must equal the CNT_W of the connected interface instance).
module if_id_hazard #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input logic           clk,
  input logic           rst_n,
  if_id_hazard_if.slave bus
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        is_branch;
  logic        load_use;
  logic        br_dep_ex;
  logic        br_load_mem;
  logic        stall;
  logic        taken;
  logic        flush;

  // Register $0 is hardwired, so it can never be a true dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] a,
                                     input logic [4:0] b);
    return (r != 5'd0) && ((r == a) || (r == b));
  endfunction

  always_comb begin
    rs          = instr_q[25:21];
    rt          = instr_q[20:16];
    is_branch   = bus.branchEqID | bus.branchNeID;
    load_use    = valid_q & bus.memReadEX & reg_match(bus.writeRegEX, rs, rt);
    br_dep_ex   = valid_q & is_branch & bus.regWriteEX & reg_match(bus.writeRegEX, rs, rt);
    // A load one stage further on still has no forwardable value for the ID comparator.
    br_load_mem = valid_q & is_branch & bus.memReadMEM & reg_match(bus.writeRegMEM, rs, rt);
    stall       = load_use | br_dep_ex | br_load_mem;
    taken       = bus.jumpID | (bus.branchEqID & bus.regsEqualID) |
                  (bus.branchNeID & ~bus.regsEqualID);
    // Branch operands are stale while stalled, so the outcome is not trusted yet.
    flush       = valid_q & taken & ~stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else if (stall) begin
      pc_q    <= pc_q;
      instr_q <= instr_q;
      valid_q <= valid_q;
    end else if (flush) begin
      pc_q    <= bus.pcAdd4IF;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= bus.pcAdd4IF;
      instr_q <= bus.instructionIF;
      valid_q <= 1'b1;
    end
  end

  assign bus.pcAdd4ID      = pc_q;
  assign bus.instructionID = instr_q;
  assign bus.validID       = valid_q;
  assign bus.pcWrite       = ~stall;
  assign bus.idexBubble    = stall;
  assign bus.ifFlush       = flush;

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CntOne;
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CntOne;
    end
  end

  assign bus.stallCount = stall_cnt_q;
  assign bus.flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed self-checking bench for if_id_hazard. Expected outputs are pushed to a
// scoreboard queue as each step is driven and popped when the DUT outputs are sampled.
// With HAZARD_STATS_EN a second instance (CNT_W = 2) shares the stimulus to show
// counter saturation.
module tb_if_id_hazard;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        pw;
    logic        bub;
    logic        fl;
  } exp_t;

  exp_t sb[$];

`ifdef HAZARD_STATS_EN
  if_id_hazard_if #(.CNT_W(16)) b ();
  if_id_hazard_if #(.CNT_W(2))  b2 ();

  if_id_hazard #(.NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  if_id_hazard #(.NOP_INSTR(32'h0000_0000), .CNT_W(2)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  assign b2.pcAdd4IF      = b.pcAdd4IF;
  assign b2.instructionIF = b.instructionIF;
  assign b2.branchEqID    = b.branchEqID;
  assign b2.branchNeID    = b.branchNeID;
  assign b2.jumpID        = b.jumpID;
  assign b2.regsEqualID   = b.regsEqualID;
  assign b2.memReadEX     = b.memReadEX;
  assign b2.regWriteEX    = b.regWriteEX;
  assign b2.writeRegEX    = b.writeRegEX;
  assign b2.memReadMEM    = b.memReadMEM;
  assign b2.writeRegMEM   = b.writeRegMEM;
`else
  if_id_hazard_if b ();

  if_id_hazard #(.NOP_INSTR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic v,
                          input logic pw, input logic bub, input logic fl);
    exp_t e;
    e.pc = pc; e.instr = instr; e.valid = v; e.pw = pw; e.bub = bub; e.fl = fl;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag);
    exp_t e;
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp(tag, "pcAdd4ID",      b.pcAdd4ID,              e.pc);
      cmp(tag, "instructionID", b.instructionID,         e.instr);
      cmp(tag, "validID",       {31'd0, b.validID},      {31'd0, e.valid});
      cmp(tag, "pcWrite",       {31'd0, b.pcWrite},      {31'd0, e.pw});
      cmp(tag, "idexBubble",    {31'd0, b.idexBubble},   {31'd0, e.bub});
      cmp(tag, "ifFlush",       {31'd0, b.ifFlush},      {31'd0, e.fl});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    b.branchEqID  = 1'b0;
    b.branchNeID  = 1'b0;
    b.jumpID      = 1'b0;
    b.regsEqualID = 1'b0;
    b.memReadEX   = 1'b0;
    b.regWriteEX  = 1'b0;
    b.writeRegEX  = 5'd0;
    b.memReadMEM  = 1'b0;
    b.writeRegMEM = 5'd0;
  endtask

  task automatic set_if(input logic [31:0] pc, input logic [31:0] instr);
    b.pcAdd4IF      = pc;
    b.instructionIF = instr;
  endtask

  localparam logic [31:0] AddI  = 32'h010A_4820; // add $9,$8,$10
  localparam logic [31:0] LwI   = 32'h8C0B_0000; // lw  $11,0($0)
  localparam logic [31:0] BeqI  = 32'h1100_0003; // beq $8,$0
  localparam logic [31:0] BneI  = 32'h1464_0002; // bne $3,$4
  localparam logic [31:0] AddiI = 32'h2129_0001; // addi $9,$9,1
  localparam logic [31:0] JI    = 32'h0800_0040; // j
  localparam logic [31:0] Add2I = 32'h0109_5020; // add $10,$8,$9
  localparam logic [31:0] LuiI  = 32'h3C01_0001; // lui $1,1

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr();
    set_if(32'd0, 32'd0);
    #1;
    push_exp(32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset");

    #8;
    rst_n = 1'b1;
    set_if(32'h104, AddI);
    push_exp(32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_load");

    tick();
    b.memReadEX  = 1'b1;
    b.writeRegEX = 5'd8;
    set_if(32'h108, LwI);
    push_exp(32'h104, AddI, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("loaduse_stall");

    tick();
    clr();
    push_exp(32'h104, AddI, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("loaduse_release");

    tick();
    b.memReadEX  = 1'b1;
    b.writeRegEX = 5'd0;
    set_if(32'h10C, BeqI);
    push_exp(32'h108, LwI, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("zero_reg");

    tick();
    clr();
    b.branchEqID  = 1'b1;
    b.regsEqualID = 1'b1;
    b.memReadEX   = 1'b1;
    b.regWriteEX  = 1'b1;
    b.writeRegEX  = 5'd8;
    set_if(32'h110, 32'h2222_0001);
    push_exp(32'h10C, BeqI, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("beq_load_ex");

    tick();
    b.memReadEX   = 1'b0;
    b.regWriteEX  = 1'b0;
    b.writeRegEX  = 5'd0;
    b.memReadMEM  = 1'b1;
    b.writeRegMEM = 5'd8;
    push_exp(32'h10C, BeqI, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("beq_load_mem");

    tick();
    b.memReadMEM  = 1'b0;
    b.writeRegMEM = 5'd0;
    push_exp(32'h10C, BeqI, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("beq_taken");

    tick();
    // Branch inputs left asserted: an invalid slot must not flush.
    push_exp(32'h110, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_nop");

    clr();
    set_if(32'h114, BneI);
    tick();
    b.branchNeID  = 1'b1;
    b.regsEqualID = 1'b0;
    set_if(32'h118, AddiI);
    push_exp(32'h114, BneI, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("bne_taken");

    b.regsEqualID = 1'b1;
    push_exp(32'h114, BneI, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bne_not_taken");

    tick();
    clr();
    push_exp(32'h118, AddiI, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bne_latch");

    b.memReadEX  = 1'b1;
    b.writeRegEX = 5'd9;
    set_if(32'h11C, JI);
    push_exp(32'h118, AddiI, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("dup_rs_rt");

    tick();
    push_exp(32'h118, AddiI, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("dup_held");
    clr();

    tick();
    b.jumpID     = 1'b1;
    b.regWriteEX = 1'b1;
    b.writeRegEX = 5'd5;
    set_if(32'h120, Add2I);
    push_exp(32'h11C, JI, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("jump_flush");

    tick();
    clr();
    set_if(32'h124, Add2I);
    push_exp(32'h120, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jump_nop");

`ifdef HAZARD_STATS_EN
    cmp("stats", "stallCount",       32'(b.stallCount),  32'd4);
    cmp("stats", "flushCount",       32'(b.flushCount),  32'd2);
    cmp("stats", "stallCount_sat",   32'(b2.stallCount), 32'd3);
    cmp("stats", "flushCount_small", 32'(b2.flushCount), 32'd2);
`endif

    tick();
    b.memReadEX  = 1'b1;
    b.writeRegEX = 5'd9;
    push_exp(32'h124, Add2I, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_stall");

    rst_n = 1'b0;
    push_exp(32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_async");
`ifdef HAZARD_STATS_EN
    cmp("rst_async", "stallCount", 32'(b.stallCount), 32'd0);
    cmp("rst_async", "flushCount", 32'(b.flushCount), 32'd0);
`endif

    #1;
    set_if(32'h128, LuiI);
    rst_n = 1'b1;
    tick();
    clr();
    push_exp(32'h128, LuiI, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_rst_load");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
